// File: rtl/mu0_pkg.sv
// rtl/mu0_pkg.sv - MU0 opcodes, FSM state encodings and the memory-opcode helper
package mu0_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JGE = 4'h5;
  localparam logic [3:0] OP_JNE = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;
  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_AND = 4'h9;
  localparam logic [3:0] OP_OR  = 4'hA;
  localparam logic [3:0] OP_NOT = 4'hB;
  localparam logic [3:0] OP_JSR = 4'hC;
  localparam logic [3:0] OP_RET = 4'hD;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_EXECUTE = 2'd1,
    ST_HALT    = 2'd2
  } state_t;

  // Opcodes that touch memory in EXECUTE and therefore wait for mem_ready.
  function automatic logic is_mem_op(input logic [3:0] op);
    case (op)
      OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND, OP_OR: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mu0_alu.sv
// rtl/mu0_alu.sv - combinational MU0 accumulator update
module mu0_alu
  import mu0_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] mem,
  input  logic [ADDR_W-1:0] operand,
  output logic [DATA_W-1:0] acc_next
);

  // Non-ALU opcodes hand the accumulator back unchanged.
  always_comb begin
    acc_next = acc;
    case (op)
      OP_LDA:  acc_next = mem;
      OP_ADD:  acc_next = acc + mem;
      OP_SUB:  acc_next = acc - mem;
      OP_LDI:  acc_next = DATA_W'(operand);
      OP_AND:  acc_next = acc & mem;
      OP_OR:   acc_next = acc | mem;
      OP_NOT:  acc_next = ~acc;
      default: acc_next = acc;
    endcase
  end

endmodule

// File: rtl/mu0_core_param.sv
// rtl/mu0_core_param.sv - parametrised MU0 core with wait states and HALT
// Optional JSR/RET link register enabled by defining MU0_CALL_EN.
module mu0_core_param
  import mu0_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0] address,
  output logic              memory_read,
  output logic              memory_write,
  output logic              fetch,
  output logic              halted,
  output logic [DATA_W-1:0] acc,
  output logic [ADDR_W-1:0] pc,
  output logic [1:0]        flags
);

  state_t            state, state_next;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] acc_next;
  logic [3:0]        op;
  logic [ADDR_W-1:0] operand;
  logic              mem_op;
  logic              exec_done;
  logic              jump_taken;
  logic [ADDR_W-1:0] jump_target;

  assign op        = ir[DATA_W-1:DATA_W-4];
  assign operand   = ir[ADDR_W-1:0];
  assign mem_op    = is_mem_op(op);
  assign exec_done = (state == ST_EXECUTE) && (!mem_op || mem_ready);
  assign flags     = {acc[DATA_W-1], acc == '0};

`ifdef MU0_CALL_EN
  logic [ADDR_W-1:0] lr;
  assign jump_target = (op == OP_RET) ? lr : operand;
`else
  assign jump_target = operand;
`endif

  always_comb begin
    jump_taken = 1'b0;
    case (op)
      OP_JMP: jump_taken = 1'b1;
      OP_JGE: jump_taken = ~acc[DATA_W-1];
      OP_JNE: jump_taken = (acc != '0);
`ifdef MU0_CALL_EN
      OP_JSR, OP_RET: jump_taken = 1'b1;
`endif
      default: jump_taken = 1'b0;
    endcase
  end

  mu0_alu #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_alu (
    .op       (op),
    .acc      (acc),
    .mem      (data_in),
    .operand  (operand),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_FETCH:   if (mem_ready) state_next = ST_EXECUTE;
      ST_EXECUTE: if (exec_done) state_next = (op == OP_STP) ? ST_HALT : ST_FETCH;
      default:    state_next = ST_HALT;
    endcase
  end

  always_comb begin
    address      = pc;
    memory_read  = 1'b0;
    memory_write = 1'b0;
    data_out     = '0;
    fetch        = 1'b0;
    halted       = 1'b0;
    case (state)
      ST_FETCH: begin
        memory_read = 1'b1;
        fetch       = 1'b1;
      end
      ST_EXECUTE: begin
        address = operand;
        if (op == OP_STA) begin
          memory_write = 1'b1;
          data_out     = acc;
        end else begin
          memory_read = mem_op;
        end
      end
      default: halted = 1'b1;
    endcase
  end

  // Datapath registers: fetch latches ir and steps pc; execute retires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc  <= RESET_PC;
      acc <= '0;
      ir  <= '0;
`ifdef MU0_CALL_EN
      lr  <= '0;
`endif
    end else if (state == ST_FETCH && mem_ready) begin
      ir <= data_in;
      pc <= pc + ADDR_W'(1);
    end else if (exec_done) begin
      acc <= acc_next;
      if (jump_taken) pc <= jump_target;
`ifdef MU0_CALL_EN
      if (op == OP_JSR) lr <= pc;
`endif
    end
  end

endmodule
